// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer with manual select and round-robin auto-scan.
// Optional build macro MUX_SCAN_MASK_EN adds a per-channel mask that the scanner skips.
module mux_scan_n #(
  parameter int W        = 8,
  parameter int N        = 8,
  parameter int SW       = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            en,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]    mask,
`endif
  output logic [W-1:0]    o,
  output logic [SW-1:0]   o_sel,
  output logic            o_valid,
  output logic            scan_tick
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int               NW       = SW + 1;
  localparam logic [SW:0]      N_L      = NW'(N);

  logic [SW-1:0]    w_cur;
  logic             w_sel_legal;
  logic [W-1:0]     w_chan;
  logic             w_chan_vld;
  logic [SW-1:0]    w_ptr_next;

  logic [SW-1:0]    r_ptr;
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic [W-1:0]     r_data_p1;
  logic [SW-1:0]    r_sel_p1;
  logic             r_vld_p1;

  // Decode as a compare chain so an out-of-range index never reaches din.
  always_comb begin
    w_cur       = mode ? r_ptr : sel;
    w_sel_legal = ({1'b0, sel} < N_L);
    w_chan      = '0;
    w_chan_vld  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_cur == SW'(k)) begin
        w_chan     = din[k*W +: W];
`ifdef MUX_SCAN_MASK_EN
        w_chan_vld = !(mode && mask[k]);
`else
        w_chan_vld = 1'b1;
`endif
      end
    end
  end

`ifdef MUX_SCAN_MASK_EN
  // Nearest unmasked channel above p with wrap; p itself when all others are masked.
  function automatic logic [SW-1:0] next_unmasked(input logic [SW-1:0] p,
                                                  input logic [N-1:0]  m);
    logic [SW-1:0] res;
    logic          found;
    int            idx;
    res   = p;
    found = 1'b0;
    for (int i = 1; i < N; i++) begin
      idx = (int'(p) + i) % N;
      if (!found && !m[idx]) begin
        res   = SW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_ptr_next = next_unmasked(r_ptr, mask);
`else
  localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);

  assign w_ptr_next = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
`endif

  // Stage p1: registered channel data plus scan pointer/divider state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1 <= '0;
      r_sel_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_ptr     <= '0;
      r_div     <= '0;
      r_tick    <= 1'b0;
    end else if (en) begin
      r_data_p1 <= w_chan_vld ? w_chan : '0;
      r_sel_p1  <= w_cur;
      r_vld_p1  <= w_chan_vld;
      if (!mode) begin
        r_ptr  <= w_sel_legal ? sel : '0;
        r_div  <= '0;
        r_tick <= 1'b0;
      end else if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_ptr  <= w_ptr_next;
        r_tick <= 1'b1;
      end else begin
        r_div  <= r_div + 1'b1;
        r_tick <= 1'b0;
      end
    end
  end

  assign o         = r_data_p1;
  assign o_sel     = r_sel_p1;
  assign o_valid   = r_vld_p1;
  // A frozen block must not report an advance, so the held tick is gated by en.
  assign scan_tick = r_tick & en;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: an N=8/SCAN_DIV=4 instance and an N=6/SCAN_DIV=1 instance.
module tb_mux_scan_n;

  typedef struct packed {
    logic [7:0] o8;
    logic [2:0] s8;
    logic       v8;
    logic       t8;
    logic [7:0] o6;
    logic [2:0] s6;
    logic       v6;
    logic       t6;
  } obs_t;

  localparam int DIV8 = 4;

  logic        clk;
  logic        rst_n;
  logic [63:0] din8;
  logic [47:0] din6;
  logic [2:0]  sel;
  logic        mode;
  logic        en;
`ifdef MUX_SCAN_MASK_EN
  logic [7:0]  mask;
`endif
  logic [7:0]  o8, o6;
  logic [2:0]  osel8, osel6;
  logic        ov8, ov6, tick8, tick6;
  obs_t        obs;

  int tests = 0;
  int fails = 0;

  obs_t sb[$];

  logic [7:0] m8_o, m6_o;
  int         m8_ptr, m8_div, m8_s, m6_ptr, m6_s;
  bit         m8_v, m8_t, m6_v, m6_t;

  mux_scan_n #(.W(8), .N(8), .SW(3), .SCAN_DIV(DIV8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask),
`endif
    .o(o8), .o_sel(osel8), .o_valid(ov8), .scan_tick(tick8));

  mux_scan_n #(.W(8), .N(6), .SW(3), .SCAN_DIV(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
    .mask(6'h00),
`endif
    .o(o6), .o_sel(osel6), .o_valid(ov6), .scan_tick(tick6));

  assign obs = {o8, osel8, ov8, tick8, o6, osel6, ov6, tick6};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int next8(int p);
    int r;
    r = (p + 1) % 8;
`ifdef MUX_SCAN_MASK_EN
    r = p;
    for (int i = 7; i >= 1; i--)
      if (!mask[(p + i) % 8]) r = (p + i) % 8;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m8_o = 8'h00; m8_ptr = 0; m8_div = 0; m8_s = 0; m8_v = 0; m8_t = 0;
    m6_o = 8'h00; m6_ptr = 0; m6_s = 0; m6_v = 0; m6_t = 0;
    sb.delete();
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_edge();
    obs_t e;
    int   c;
    if (en) begin
      c    = mode ? m8_ptr : int'(sel);
      m8_s = c;
      m8_v = 1'b1;
      m8_o = din8[c*8 +: 8];
`ifdef MUX_SCAN_MASK_EN
      if (mode && mask[c]) begin m8_v = 1'b0; m8_o = 8'h00; end
`endif
      if (!mode) begin
        m8_ptr = int'(sel); m8_div = 0; m8_t = 0;
      end else if (m8_div == DIV8 - 1) begin
        m8_div = 0; m8_ptr = next8(m8_ptr); m8_t = 1;
      end else begin
        m8_div++; m8_t = 0;
      end
      c    = mode ? m6_ptr : int'(sel);
      m6_s = c;
      m6_v = (c < 6);
      if (m6_v) m6_o = din6[c*8 +: 8];
      else      m6_o = 8'h00;
      if (!mode) begin
        m6_ptr = (int'(sel) < 6) ? int'(sel) : 0; m6_t = 0;
      end else begin
        m6_ptr = (m6_ptr == 5) ? 0 : m6_ptr + 1; m6_t = 1;
      end
    end
    e = {m8_o, 3'(m8_s), m8_v, m8_t & en, m6_o, 3'(m6_s), m6_v, m6_t & en};
    sb.push_back(e);
  endtask

  task automatic tick_clk();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; sel = 3'd3; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_state got=%h want=0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_manual_sweep();
    obs_t       e;
    logic [7:0] tbl [8];
    tbl  = '{8'hA0, 8'h51, 8'hA2, 8'h53, 8'hA4, 8'h55, 8'hA6, 8'h57};
    mode = 1'b0; en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      for (int c = 0; c < 5; c++) begin
        tick_clk();
        e = sb.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL sb_manual got=%h want=%h", obs, e); end
        if (c == 0) begin
          tests++;
          if (o8 !== tbl[s] || osel8 !== 3'(s) || ov8 !== 1'b1) begin
            fails++;
            $display("FAIL manual_ch%0d got o=%h sel=%0d v=%b want o=%h sel=%0d v=1",
                     s, o8, osel8, ov8, tbl[s], s);
          end
        end
      end
    end
  endtask

  task automatic test_illegal_select();
    obs_t e;
    mode = 1'b0; sel = 3'd7;
    tick_clk();
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL sb_illegal got=%h want=%h", obs, e); end
    tests++;
    if (o6 !== 8'h00 || ov6 !== 1'b0 || osel6 !== 3'd7) begin
      fails++; $display("FAIL illegal_sel7 got o=%h v=%b sel=%0d want o=00 v=0 sel=7", o6, ov6, osel6);
    end
    sel = 3'd5;
    tick_clk();
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL sb_illegal got=%h want=%h", obs, e); end
    tests++;
    if (o6 !== 8'h65 || ov6 !== 1'b1 || osel6 !== 3'd5) begin
      fails++; $display("FAIL legal_sel5 got o=%h v=%b sel=%0d want o=65 v=1 sel=5", o6, ov6, osel6);
    end
  endtask

  task automatic test_auto_wrap();
    obs_t       e;
    logic [7:0] seq[$];
    int         tk[$];
    logic [7:0] want [4];
    want = '{8'hA6, 8'h57, 8'hA0, 8'h51};
    mode = 1'b0; sel = 3'd6;
    repeat (2) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_auto got=%h want=%h", obs, e); end
    end
    mode = 1'b1; sel = 3'd2;
    for (int c = 1; c <= 16; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_auto got=%h want=%h", obs, e); end
      if (seq.size() == 0 || seq[$] !== o8) seq.push_back(o8);
      if (tick8 === 1'b1) tk.push_back(c);
      tests++;
      if (tick6 !== 1'b1) begin fails++; $display("FAIL div1_tick cycle %0d got=%b want=1", c, tick6); end
    end
    tests++;
    if (seq.size() < 4) begin
      fails++; $display("FAIL auto_seq_len got=%0d want>=4", seq.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (seq[i] !== want[i]) begin
          fails++; $display("FAIL auto_seq[%0d] got=%h want=%h", i, seq[i], want[i]); break;
        end
    end
    tests++;
    if (tk.size() != 4 || tk[0] != 4 || tk[1] != 8 || tk[2] != 12 || tk[3] != 16) begin
      fails++; $display("FAIL auto_tick_period got count=%0d first=%0d want 4 ticks at 4,8,12,16",
                        tk.size(), (tk.size() > 0) ? tk[0] : -1);
    end
  endtask

  task automatic test_enable_hold();
    obs_t       e;
    logic [7:0] o_hold;
    int         n;
    bit         seen;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_hold got=%h want=%h", obs, e); end
      if (tick8 === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL hold_pre_tick got=none want=tick within 10"); end
    tick_clk();
    e = sb.pop_front();
    o_hold = o8;
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_hold got=%h want=%h", obs, e); end
      tests++;
      if (tick8 !== 1'b0 || tick6 !== 1'b0 || o8 !== o_hold) begin
        fails++; $display("FAIL hold_frozen got o=%h t8=%b t6=%b want o=%h t=0", o8, tick8, tick6, o_hold);
      end
    end
    en = 1'b1;
    n  = 0;
    seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_hold got=%h want=%h", obs, e); end
      if (tick8 === 1'b1) begin seen = 1; n = c; end
    end
    tests++;
    if (n != 3) begin fails++; $display("FAIL hold_resume got=%0d want=3 cycles to tick", n); end
  endtask

  task automatic test_auto_to_manual();
    obs_t e;
    mode = 1'b0; sel = 3'd2;
    tick_clk();
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL sb_to_manual got=%h want=%h", obs, e); end
    tests++;
    if (o8 !== 8'hA2 || osel8 !== 3'd2 || tick8 !== 1'b0) begin
      fails++; $display("FAIL to_manual got o=%h sel=%0d t=%b want o=A2 sel=2 t=0", o8, osel8, tick8);
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    bit   found;
    int   first;
    found = 0;
    mode  = 1'b1;
    for (int c = 0; c < 64; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_areset got=%h want=%h", obs, e); end
      if (m8_ptr == 5) begin found = 1; break; end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL areset_reach_ptr5 got=%0d want=5", m8_ptr); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (o8 !== 8'h00 || ov8 !== 1'b0 || osel8 !== 3'd0 || tick8 !== 1'b0) begin
      fails++; $display("FAIL areset_immediate got o=%h v=%b sel=%0d t=%b want all 0", o8, ov8, osel8, tick8);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int c = 1; c <= 12; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_areset got=%h want=%h", obs, e); end
      if (tick8 === 1'b1 && first == 0) first = c;
      if (c == 1) begin
        tests++;
        if (o8 !== 8'hA0) begin fails++; $display("FAIL areset_first_o got=%h want=A0", o8); end
      end
      if (c == 5) begin
        tests++;
        if (o8 !== 8'h51) begin fails++; $display("FAIL areset_second_o got=%h want=51", o8); end
      end
    end
    tests++;
    if (first != DIV8) begin fails++; $display("FAIL areset_first_tick got=%0d want=%0d", first, DIV8); end
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask();
    obs_t       e;
    logic [2:0] seq[$];
    logic [2:0] want [5];
    want = '{3'd0, 3'd3, 3'd4, 3'd7, 3'd0};
    mode = 1'b0; sel = 3'd0;
    repeat (2) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_mask got=%h want=%h", obs, e); end
    end
    mask = 8'b0110_0110;
    mode = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_mask got=%h want=%h", obs, e); end
      if (seq.size() == 0 || seq[$] !== osel8) seq.push_back(osel8);
    end
    tests++;
    if (seq.size() < 5) begin
      fails++; $display("FAIL mask_order_len got=%0d want>=5", seq.size());
    end else begin
      for (int i = 0; i < 5; i++)
        if (seq[i] !== want[i]) begin
          fails++; $display("FAIL mask_order[%0d] got=%0d want=%0d", i, seq[i], want[i]); break;
        end
    end
    mask = 8'hFF;
    for (int c = 1; c <= 12; c++) begin
      tick_clk();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sb_mask_all got=%h want=%h", obs, e); end
      tests++;
      if (ov8 !== 1'b0 || osel8 !== 3'd3 || o8 !== 8'h00) begin
        fails++; $display("FAIL mask_all got v=%b sel=%0d o=%h want v=0 sel=3 o=00", ov8, osel8, o8);
      end
    end
    mask = 8'h00;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b0;
    sel   = 3'd0;
    din8  = {8'h57, 8'hA6, 8'h55, 8'hA4, 8'h53, 8'hA2, 8'h51, 8'hA0};
    din6  = {8'h65, 8'h54, 8'h43, 8'h32, 8'h21, 8'h10};
`ifdef MUX_SCAN_MASK_EN
    mask  = 8'h00;
`endif
    model_reset();
    test_reset();
    test_manual_sweep();
    test_illegal_select();
    test_auto_wrap();
    test_enable_hold();
    test_auto_to_manual();
    test_async_reset();
`ifdef MUX_SCAN_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
